led_pattern_gen: RTL and testbench



---
 rtl/led_pattern_gen.sv | 167 ++++++++++++++++
 tb/tb_led_pattern_gen.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/led_pattern_gen.sv
// LED pattern engine: blink, chase, bounce and PWM breathe driven by a step prescaler.
// Define LED_ACTIVE_LOW_EN to invert the LED drive for active-low boards.
module led_pattern_gen #(
  parameter int unsigned CLK_FREQ  = 50_000_000,
  parameter int unsigned STEP_FREQ = 4,
  parameter int unsigned NUM_LEDS  = 18,
  parameter int unsigned PWM_BITS  = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [1:0]          mode,
  input  logic                pause,
  output logic [NUM_LEDS-1:0] leds,
  output logic                step_tick
);

  localparam int unsigned          STEP_MAX = CLK_FREQ / STEP_FREQ - 1;
  localparam int unsigned          POS_W    = (NUM_LEDS > 1) ? $clog2(NUM_LEDS) : 1;
  localparam logic [31:0]          CNT_LAST = 32'(STEP_MAX);
  localparam logic [POS_W-1:0]     POS_LAST = POS_W'(NUM_LEDS - 1);
  localparam logic [PWM_BITS-1:0]  DUTY_MAX = '1;
  localparam logic [NUM_LEDS-1:0]  ONE_HOT0 = NUM_LEDS'(1);
`ifdef LED_ACTIVE_LOW_EN
  localparam logic [NUM_LEDS-1:0]  LEDS_RST = '1;
`else
  localparam logic [NUM_LEDS-1:0]  LEDS_RST = '0;
`endif

  typedef enum logic [1:0] {
    ModeBlink   = 2'd0,
    ModeChase   = 2'd1,
    ModeBounce  = 2'd2,
    ModeBreathe = 2'd3
  } mode_e;

  typedef enum logic {
    DirUp   = 1'b0,
    DirDown = 1'b1
  } dir_e;

  mode_e                mode_q;
  logic [31:0]          cnt_q, cnt_d;
  logic [POS_W-1:0]     pos_q, pos_d;
  dir_e                 dir_q, dir_d;
  logic                 phase_q, phase_d;
  logic [PWM_BITS-1:0]  duty_q, duty_d;
  logic [PWM_BITS-1:0]  pwm_cnt_q, pwm_cnt_d;
  logic                 tick_q;
  logic [NUM_LEDS-1:0]  leds_q, leds_d;
  logic [NUM_LEDS-1:0]  leds_pat;
  logic                 mode_chg;
  logic                 tick;

  assign mode_chg = (mode != mode_q);
  // A mode change swallows a coincident tick so the new pattern starts cleanly.
  assign tick     = !mode_chg && !pause && (cnt_q == CNT_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mode_q    <= ModeBlink;
      cnt_q     <= '0;
      pos_q     <= '0;
      dir_q     <= DirUp;
      phase_q   <= 1'b0;
      duty_q    <= '0;
      pwm_cnt_q <= '0;
      tick_q    <= 1'b0;
      leds_q    <= LEDS_RST;
    end else begin
      mode_q    <= mode_e'(mode);
      cnt_q     <= cnt_d;
      pos_q     <= pos_d;
      dir_q     <= dir_d;
      phase_q   <= phase_d;
      duty_q    <= duty_d;
      pwm_cnt_q <= pwm_cnt_d;
      tick_q    <= tick;
      leds_q    <= leds_d;
    end
  end

  always_comb begin
    cnt_d     = cnt_q;
    pos_d     = pos_q;
    dir_d     = dir_q;
    phase_d   = phase_q;
    duty_d    = duty_q;
    pwm_cnt_d = pwm_cnt_q + 1'b1;

    if (mode_chg) begin
      cnt_d   = '0;
      pos_d   = '0;
      dir_d   = DirUp;
      phase_d = 1'b0;
      duty_d  = '0;
    end else if (!pause) begin
      cnt_d = tick ? '0 : cnt_q + 32'd1;
      if (tick) begin
        unique case (mode_q)
          ModeBlink: begin
            phase_d = ~phase_q;
          end
          ModeChase: begin
            pos_d = (pos_q == POS_LAST) ? '0 : pos_q + 1'b1;
          end
          ModeBounce: begin
            if (NUM_LEDS > 1) begin
              if (dir_q == DirUp) begin
                if (pos_q == POS_LAST) begin
                  dir_d = DirDown;
                  pos_d = pos_q - 1'b1;
                end else begin
                  pos_d = pos_q + 1'b1;
                end
              end else begin
                if (pos_q == '0) begin
                  dir_d = DirUp;
                  pos_d = pos_q + 1'b1;
                end else begin
                  pos_d = pos_q - 1'b1;
                end
              end
            end
          end
          ModeBreathe: begin
            // Endpoints reverse and step in the same tick, so each is held one step.
            if (dir_q == DirUp) begin
              if (duty_q == DUTY_MAX) begin
                dir_d  = DirDown;
                duty_d = duty_q - 1'b1;
              end else begin
                duty_d = duty_q + 1'b1;
              end
            end else begin
              if (duty_q == '0) begin
                dir_d  = DirUp;
                duty_d = duty_q + 1'b1;
              end else begin
                duty_d = duty_q - 1'b1;
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

  always_comb begin
    leds_pat = '0;
    unique case (mode_q)
      ModeBlink:              leds_pat = {NUM_LEDS{phase_q}};
      ModeChase, ModeBounce:  leds_pat = ONE_HOT0 << pos_q;
      ModeBreathe:            leds_pat = {NUM_LEDS{pwm_cnt_q < duty_q}};
      default:                leds_pat = '0;
    endcase
`ifdef LED_ACTIVE_LOW_EN
    leds_d = ~leds_pat;
`else
    leds_d = leds_pat;
`endif
  end

  assign leds      = leds_q;
  assign step_tick = tick_q;

endmodule

// File: tb/tb_led_pattern_gen.sv
// Directed bench for led_pattern_gen: table-driven pattern walk plus pause, reset and breathe
// sequences. Honours LED_ACTIVE_LOW_EN by inverting expected LED values.
module tb_led_pattern_gen;

  localparam int unsigned NL = 4;
`ifdef LED_ACTIVE_LOW_EN
  localparam logic [NL-1:0] INV = '1;
`else
  localparam logic [NL-1:0] INV = '0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic [1:0]    mode;
  logic          pause;
  logic [NL-1:0] leds;
  logic          step_tick;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    int            adv;
    logic [1:0]    mode;
    logic [NL-1:0] leds;
    logic          tick;
  } vec_t;

  vec_t vecs[22];

  led_pattern_gen #(
    .CLK_FREQ (20),
    .STEP_FREQ(2),
    .NUM_LEDS (NL),
    .PWM_BITS (2)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .mode     (mode),
    .pause    (pause),
    .leds     (leds),
    .step_tick(step_tick)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic adv(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check_leds(input string name, input logic [NL-1:0] exp);
    n_tests++;
    if (leds !== (exp ^ INV)) begin
      n_fail++;
      $display("FAIL %s: leds=%b required %b", name, leds, exp ^ INV);
    end
  endtask

  task automatic check_tick(input string name, input logic exp);
    n_tests++;
    if (step_tick !== exp) begin
      n_fail++;
      $display("FAIL %s: step_tick=%b required %b", name, step_tick, exp);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d required %0d", name, act, exp);
    end
  endtask

  // Holds reset for two edges, releases it just after an edge (edge 0 of the run).
  task automatic reset_release();
    rst = 1'b1;
    adv(2);
    rst = 1'b0;
  endtask

  initial begin
    int bad_leds;
    int ticks;
    int lit;
    int mixed;
    int exp_duty[8];

    // Edge numbers relative to reset release; tick at edge 10k, leds update one edge later.
    vecs[0]  = '{1,  2'd0, 4'b0000, 1'b0};
    vecs[1]  = '{9,  2'd0, 4'b0000, 1'b1};
    vecs[2]  = '{1,  2'd0, 4'b1111, 1'b0};
    vecs[3]  = '{9,  2'd0, 4'b1111, 1'b1};
    vecs[4]  = '{1,  2'd0, 4'b0000, 1'b0};
    vecs[5]  = '{2,  2'd1, 4'b0001, 1'b0};
    vecs[6]  = '{9,  2'd1, 4'b0001, 1'b1};
    vecs[7]  = '{1,  2'd1, 4'b0010, 1'b0};
    vecs[8]  = '{9,  2'd1, 4'b0010, 1'b1};
    vecs[9]  = '{1,  2'd1, 4'b0100, 1'b0};
    vecs[10] = '{10, 2'd1, 4'b1000, 1'b0};
    vecs[11] = '{10, 2'd1, 4'b0001, 1'b0};
    vecs[12] = '{2,  2'd2, 4'b0001, 1'b0};
    vecs[13] = '{10, 2'd2, 4'b0010, 1'b0};
    vecs[14] = '{10, 2'd2, 4'b0100, 1'b0};
    vecs[15] = '{10, 2'd2, 4'b1000, 1'b0};
    vecs[16] = '{10, 2'd2, 4'b0100, 1'b0};
    vecs[17] = '{10, 2'd2, 4'b0010, 1'b0};
    vecs[18] = '{10, 2'd2, 4'b0001, 1'b0};
    vecs[19] = '{10, 2'd2, 4'b0010, 1'b0};
    vecs[20] = '{9,  2'd2, 4'b0010, 1'b1};
    vecs[21] = '{1,  2'd2, 4'b0100, 1'b0};

    exp_duty[0] = 0; exp_duty[1] = 1; exp_duty[2] = 2; exp_duty[3] = 3;
    exp_duty[4] = 2; exp_duty[5] = 1; exp_duty[6] = 0; exp_duty[7] = 1;

    rst   = 1'b1;
    mode  = 2'd0;
    pause = 1'b0;
    adv(2);
    check_leds("reset_leds", 4'b0000);
    check_tick("reset_tick", 1'b0);
    rst = 1'b0;

    for (int i = 0; i < 22; i++) begin
      mode = vecs[i].mode;
      adv(vecs[i].adv);
      check_leds($sformatf("vec%0d_leds", i), vecs[i].leds);
      check_tick($sformatf("vec%0d_tick", i), vecs[i].tick);
    end

    // Pause mid-chase at 0100: cnt=4 when frozen, so the step resumes 35 cycles late.
    mode  = 2'd1;
    pause = 1'b0;
    reset_release();
    adv(22);
    check_leds("pause_pre", 4'b0100);
    adv(3);
    pause    = 1'b1;
    bad_leds = 0;
    ticks    = 0;
    for (int i = 0; i < 35; i++) begin
      adv(1);
      if (leds !== (4'b0100 ^ INV)) bad_leds++;
      if (step_tick !== 1'b0) ticks++;
    end
    check_int("pause_hold_leds_bad", bad_leds, 0);
    check_int("pause_tick_count", ticks, 0);
    pause = 1'b0;
    adv(5);
    check_tick("resume_early", 1'b0);
    adv(1);
    check_tick("resume_tick", 1'b1);
    adv(1);
    check_leds("resume_leds", 4'b1000);
    pause = 1'b1;
    mode  = 2'd2;
    adv(2);
    check_leds("modechg_paused_leds", 4'b0001);
    pause = 1'b0;
    adv(9);
    check_tick("cnt_cleared_early", 1'b0);
    adv(1);
    check_tick("cnt_cleared_tick", 1'b1);

    // Bounce to pos 2 heading down, then asynchronous reset between edges.
    mode = 2'd2;
    reset_release();
    adv(32);
    check_leds("bounce_top", 4'b1000);
    adv(10);
    check_leds("bounce_pos2_down", 4'b0100);
    adv(3);
    rst  = 1'b1;
    mode = 2'd0;
    #2;
    check_leds("async_reset_leds", 4'b0000);
    check_tick("async_reset_tick", 1'b0);
    adv(2);
    rst = 1'b0;
    adv(9);
    check_tick("post_reset_early", 1'b0);
    adv(1);
    check_tick("post_reset_tick", 1'b1);
    adv(1);
    check_leds("post_reset_blink", 4'b1111);

    // Breathe: 8-cycle windows inside each step; lit cycles = 2 * duty for a 4-cycle PWM.
    mode = 2'd3;
    reset_release();
    adv(2);
    for (int k = 0; k < 8; k++) begin
      adv(1);
      lit   = 0;
      mixed = 0;
      for (int j = 0; j < 8; j++) begin
        if (j > 0) adv(1);
        if ((leds ^ INV) == 4'b1111) lit++;
        else if ((leds ^ INV) != 4'b0000) mixed++;
      end
      check_int($sformatf("breathe_step%0d_lit", k), lit, 2 * exp_duty[k]);
      check_int($sformatf("breathe_step%0d_mixed", k), mixed, 0);
      adv(2);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
